// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with single-cycle ops and a WIDTH-cycle shift-add multiplier.
// Defining ALU_MULTICYCLE_DIV_EN adds a WIDTH-cycle unsigned restoring divider (divu 1101, remu 1110).
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Zero,
  output logic             illegal_op
);
  typedef enum logic [1:0] {IDLE, MUL, DONE, DIV} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] acc, mcand, mplier, acc_nx, alu;
  logic [SHW-1:0] cnt, sh;
  logic legal, is_mul, is_div, last;
  assign sh = b[SHW-1:0];
  assign is_mul = ALUop == 4'b0011;
  assign last = cnt == SHW'(WIDTH - 1);
  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
`ifdef ALU_MULTICYCLE_DIV_EN
  // acc holds the partial remainder, mplier shifts the dividend out and quotient bits in, mcand is the divisor
  logic [WIDTH:0] trial;
  logic ge, is_rem;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  assign is_div = ALUop == 4'b1101 || ALUop == 4'b1110;
  assign trial = {acc, mplier[WIDTH-1]};
  assign ge = trial >= {1'b0, mcand};
  assign rem_nx = ge ? WIDTH'(trial - {1'b0, mcand}) : trial[WIDTH-1:0];
  assign quo_nx = {mplier[WIDTH-2:0], ge};
`else
  assign is_div = 1'b0;
`endif
  always_comb begin
    alu = '0;
    legal = 1'b1;
    case (ALUop)
      4'b0000: alu = a & b;
      4'b0001: alu = a | b;
      4'b0010: alu = a + b;
      4'b0110: alu = a - b;
      4'b1100: alu = ~(a | b);
      4'b1000: alu = a << sh;
      4'b1001: alu = a >> sh;
      4'b1010: alu = WIDTH'($signed(a) >>> sh);
      4'b0111: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0011: alu = '0;
`ifdef ALU_MULTICYCLE_DIV_EN
      4'b1101, 4'b1110: alu = '0;
`endif
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = !in_valid ? IDLE : is_mul ? MUL : is_div ? DIV : DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = last ? DONE : state;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
      result <= '0;
      Zero <= 1'b1;
      illegal_op <= 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
      is_rem <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= '0;
          mcand <= is_div ? b : a;
          mplier <= is_div ? a : b;
          cnt <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
          is_rem <= ALUop[1];
`endif
          if (!is_mul && !is_div) begin
            result <= alu;
            Zero <= alu == '0;
            illegal_op <= !legal;
          end
        end
        MUL: begin
          acc <= acc_nx;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= acc_nx;
            Zero <= acc_nx == '0;
            illegal_op <= 1'b0;
          end
        end
`ifdef ALU_MULTICYCLE_DIV_EN
        DIV: begin
          acc <= rem_nx;
          mplier <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= is_rem ? rem_nx : quo_nx;
            Zero <= (is_rem ? rem_nx : quo_nx) == '0;
            illegal_op <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: randomized ops checked every cycle against a latency/arithmetic model, plus literal directed checks.
module tb_alu_multicycle;
  localparam int W = 64;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 1;
  logic [3:0] ALUop = 0;
  logic [W-1:0] a = 0, b = 0;
  logic in_ready, out_valid, Zero, illegal_op;
  logic [W-1:0] result;
  int total = 0, bad = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUop(ALUop), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .Zero(Zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return x + y;
      4'd6: return x - y;
      4'd12: return ~(x | y);
      4'd8: return x << y[5:0];
      4'd9: return x >> y[5:0];
      4'd10: return W'($signed(x) >>> y[5:0]);
      4'd7: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'd3: return x * y;
`ifdef ALU_MULTICYCLE_DIV_EN
      4'd13: return (y == 0) ? '1 : x / y;
      4'd14: return (y == 0) ? x : x % y;
`endif
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_ill(input logic [3:0] op);
`ifdef ALU_MULTICYCLE_DIV_EN
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd8, 4'd9, 4'd10, 4'd7, 4'd3, 4'd13, 4'd14});
`else
    return !(op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd8, 4'd9, 4'd10, 4'd7, 4'd3});
`endif
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef ALU_MULTICYCLE_DIV_EN
    return (op == 4'd3 || op == 4'd13 || op == 4'd14) ? W + 1 : 1;
`else
    return (op == 4'd3) ? W + 1 : 1;
`endif
  endfunction

  // Transaction-level model: an accepted op becomes visible ref_lat cycles later and is held until taken.
  int m_wait;
  logic m_valid, m_zero, m_ill, m_ready;
  logic [W-1:0] m_res, p_res;
  assign m_ready = !m_valid && m_wait == 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_wait <= 0; m_valid <= 0; m_res <= '0; m_zero <= 1; m_ill <= 0; p_res <= '0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1; m_res <= p_res; m_zero <= p_res == '0; m_ill <= 0;
      end
    end else if (in_valid) begin
      if (ref_lat(ALUop) == 1) begin
        m_valid <= 1;
        m_res <= ref_ill(ALUop) ? '0 : ref_res(ALUop, a, b);
        m_zero <= ref_ill(ALUop) ? 1'b1 : ref_res(ALUop, a, b) == '0;
        m_ill <= ref_ill(ALUop);
      end else begin
        m_wait <= ref_lat(ALUop) - 1;
        p_res <= ref_res(ALUop, a, b);
      end
    end
  end

  always @(negedge clk) if (reset_n) begin
    chk("in_ready", W'(in_ready), W'(m_ready));
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("result", result, m_res);
    chk("zero", W'(Zero), W'(m_zero));
    chk("illegal_op", W'(illegal_op), W'(m_ill));
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit rnd,
                       output int lat, output logic [W-1:0] r, output logic z, output logic il);
    int n;
    n = 0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    chk("ready_wait", W'(in_ready), W'(1));
    ALUop = op; a = x; b = y; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 300) begin @(negedge clk); lat++; end
    chk("valid_wait", W'(out_valid), W'(1));
    r = result; z = Zero; il = illegal_op;
    n = 0;
    forever begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
      if (out_ready || n > 300) break;
    end
    out_ready = 1;
  endtask

  int lat;
  logic [W-1:0] r;
  logic z, il;
  initial begin
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
    chk("rst_valid", W'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_zero", W'(Zero), 1);
    chk("rst_ready", W'(in_ready), 1);

    issue(4'd2, '1, 1, 0, lat, r, z, il);
    chk("add_res", r, 0); chk("add_zero", W'(z), 1); chk("add_lat", W'(lat), 1);
    issue(4'd10, 64'h8000_0000_0000_0000, 64'h43, 0, lat, r, z, il);
    chk("sra_res", r, 64'hF000_0000_0000_0000);
    issue(4'd7, '1, 0, 0, lat, r, z, il);
    chk("slt_res", r, 1);
    issue(4'd3, 64'h1_0000_0001, 3, 0, lat, r, z, il);
    chk("mul_res", r, 64'h3_0000_0003); chk("mul_lat", W'(lat), 65);

    // reset while the multiplier is at cnt=10
    in_valid = 1; ALUop = 4'd3; a = 64'h1234; b = 64'h5678;
    @(negedge clk);
    in_valid = 0;
    repeat (10) @(negedge clk);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_valid", W'(out_valid), 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_zero", W'(Zero), 1);
    chk("mid_rst_ready", W'(in_ready), 1);
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);

    issue(4'd15, 64'h55, 64'h66, 0, lat, r, z, il);
    chk("ill_res", r, 0); chk("ill_flag", W'(il), 1); chk("ill_lat", W'(lat), 1); chk("ill_zero", W'(z), 1);
`ifdef ALU_MULTICYCLE_DIV_EN
    issue(4'd13, 100, 7, 0, lat, r, z, il);
    chk("divu_res", r, 14); chk("divu_lat", W'(lat), 65);
    issue(4'd14, 100, 7, 0, lat, r, z, il);
    chk("remu_res", r, 2);
    issue(4'd13, 64'h1234, 0, 0, lat, r, z, il);
    chk("divu0_res", r, '1); chk("divu0_ill", W'(il), 0);
    issue(4'd14, 64'h1234, 0, 0, lat, r, z, il);
    chk("remu0_res", r, 64'h1234); chk("remu0_lat", W'(lat), 65);
`else
    issue(4'd13, 100, 7, 0, lat, r, z, il);
    chk("op1101_ill", W'(il), 1); chk("op1101_lat", W'(lat), 1);
`endif

    // backpressure: sub 7-7 held while a new op waits
    out_ready = 0;
    in_valid = 1; ALUop = 4'd6; a = 7; b = 7;
    @(negedge clk);
    ALUop = 4'd2; a = 1; b = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", W'(out_valid), 1);
      chk("bp_res", result, 0);
      chk("bp_zero", W'(Zero), 1);
      chk("bp_ready", W'(in_ready), 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_idle", W'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    chk("bp_next_res", result, 3);
    chk("bp_next_valid", W'(out_valid), 1);
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [W-1:0] x, y;
      op = 4'($urandom_range(0, 15));
      x = {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : {$urandom, $urandom};
      issue(op, x, y, 1, lat, r, z, il);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
